// File: rtl/ym_dac_pkg.sv
// Shared field layout of the YM2151 DAC word and its linear conversion.
package ym_dac_pkg;

  localparam int MANT_LSB = 3;
  localparam int MANT_W   = 10;
  localparam int EXP_LSB  = 13;
  localparam int EXP_W    = 3;
  localparam int RAW_W    = 13;
  localparam int LIN_W    = 16;
  localparam int SREG_W   = EXP_LSB + EXP_W;

  localparam logic [EXP_W-1:0] EXP_ZERO = '0;

endpackage

// File: rtl/ym_dac_exp2lin.sv
// Converts one 13-bit YM2151 floating-point DAC word into 16-bit signed linear.
module ym_dac_exp2lin
  import ym_dac_pkg::*;
(
  input  logic [RAW_W-1:0] raw,
  output logic [LIN_W-1:0] lin
);

  logic [EXP_W-1:0]  e;
  logic [MANT_W-1:0] m;
  logic [LIN_W-1:0]  ext;

  assign e = raw[RAW_W-1 -: EXP_W];
  assign m = raw[MANT_W-1:0];

  // The mantissa is offset binary: inverting its top bit gives two's complement.
  always_comb begin
    ext = {{(LIN_W-MANT_W){~m[MANT_W-1]}}, ~m[MANT_W-1], m[MANT_W-2:0]};
    lin = '0;
    if (e != EXP_ZERO) begin
      lin = ext << (e - 3'd1);
    end
  end

endmodule

// File: rtl/ym_dac_capture.sv
// Captures the YM2151 serial DAC stream into left/right pairs with a
// ready/ack handshake, overrun counting and a P1 watchdog.
module ym_dac_capture
  import ym_dac_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ym_p1,
  input  logic               ym_so,
  input  logic               ym_sh1,
  input  logic               ym_sh2,
  input  logic               enable,
  input  logic               rd_ack,
  output logic [RAW_W-1:0]   left_raw,
  output logic [RAW_W-1:0]   right_raw,
  output logic [LIN_W-1:0]   left,
  output logic [LIN_W-1:0]   right,
  output logic               sample_valid,
  output logic               sample_ready,
  output logic [7:0]         overrun_cnt,
  output logic               p1_lost
);

  logic [SYNC_STAGES-1:0] p1_sync, so_sync, sh1_sync, sh2_sync;
  logic                   p1_prev;
  logic                   p1_rise, so_s, sh1_s, sh2_s;
  logic                   sh1_prev, sh2_prev, sh1_fall, sh2_fall;
  // Bit 0 of the word would be shifted out unused, so only [15:1] is kept.
  logic [SREG_W-1:1]      sreg;
  logic                   left_got, pair_pend;
  logic [TIMEOUT_W-1:0]   wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_sync  <= '0;
      so_sync  <= '0;
      sh1_sync <= '0;
      sh2_sync <= '0;
      p1_prev  <= 1'b0;
    end else begin
      p1_sync  <= {p1_sync[SYNC_STAGES-2:0], ym_p1};
      so_sync  <= {so_sync[SYNC_STAGES-2:0], ym_so};
      sh1_sync <= {sh1_sync[SYNC_STAGES-2:0], ym_sh1};
      sh2_sync <= {sh2_sync[SYNC_STAGES-2:0], ym_sh2};
      p1_prev  <= p1_sync[SYNC_STAGES-1];
    end
  end

  assign p1_rise  = p1_sync[SYNC_STAGES-1] & ~p1_prev;
  assign so_s     = so_sync[SYNC_STAGES-1];
  assign sh1_s    = sh1_sync[SYNC_STAGES-1];
  assign sh2_s    = sh2_sync[SYNC_STAGES-1];
  assign sh1_fall = sh1_prev & ~sh1_s;
  assign sh2_fall = sh2_prev & ~sh2_s;

  // Strobe history is cleared while disabled so a stale high level cannot
  // latch a half-shifted word right after re-enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      sh1_prev  <= 1'b0;
      sh2_prev  <= 1'b0;
      left_raw  <= '0;
      right_raw <= '0;
      left_got  <= 1'b0;
      pair_pend <= 1'b0;
    end else if (!enable) begin
      sreg      <= '0;
      sh1_prev  <= 1'b0;
      sh2_prev  <= 1'b0;
      left_got  <= 1'b0;
      pair_pend <= 1'b0;
    end else begin
      pair_pend <= 1'b0;
      if (p1_rise) begin
        sreg     <= {so_s, sreg[SREG_W-1:2]};
        sh1_prev <= sh1_s;
        sh2_prev <= sh2_s;
        if (sh1_fall) begin
          left_raw <= sreg[SREG_W-1:MANT_LSB];
          left_got <= 1'b1;
        end
        if (sh2_fall) begin
          right_raw <= sreg[SREG_W-1:MANT_LSB];
          if (left_got) begin
            pair_pend <= 1'b1;
            left_got  <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid <= 1'b0;
      sample_ready <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      sample_valid <= pair_pend & enable;
      if (sample_valid) begin
        sample_ready <= 1'b1;
      end else if (rd_ack) begin
        sample_ready <= 1'b0;
      end
      if (sample_valid && sample_ready && !rd_ack && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (p1_rise) begin
      wd_cnt <= '0;
    end else if (!(&wd_cnt)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign p1_lost = &wd_cnt;

  ym_dac_exp2lin u_left_conv  (.raw(left_raw),  .lin(left));
  ym_dac_exp2lin u_right_conv (.raw(right_raw), .lin(right));

endmodule

// File: tb/tb_ym_dac_capture.sv
// Directed bench for ym_dac_capture: conversion vectors, pairing, overrun,
// watchdog, mid-word reset and enable gating.
module tb_ym_dac_capture;

  logic        clk = 1'b0;
  logic        rst_n, ym_p1, ym_so, ym_sh1, ym_sh2, enable;
  logic        rd_ack_man, ack_on_valid, rd_ack;
  logic [12:0] left_raw, right_raw;
  logic [15:0] left, right;
  logic        sample_valid, sample_ready, p1_lost;
  logic [7:0]  overrun_cnt;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int base;

  typedef struct {
    logic [12:0] l_raw;
    logic [12:0] r_raw;
    logic [15:0] l_lin;
    logic [15:0] r_lin;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  // Lets the bench raise rd_ack in exactly the cycle a pair is announced.
  assign rd_ack = rd_ack_man | (ack_on_valid & sample_valid);

  always @(negedge clk) begin
    if (sample_valid) valid_cnt++;
  end

  ym_dac_capture #(.SYNC_STAGES(2), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ym_p1(ym_p1), .ym_so(ym_so),
    .ym_sh1(ym_sh1), .ym_sh2(ym_sh2), .enable(enable), .rd_ack(rd_ack),
    .left_raw(left_raw), .right_raw(right_raw), .left(left), .right(right),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun_cnt(overrun_cnt), .p1_lost(p1_lost)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic so, input logic s1, input logic s2);
    @(negedge clk);
    ym_so = so; ym_sh1 = s1; ym_sh2 = s2; ym_p1 = 1'b0;
    repeat (3) @(negedge clk);
    ym_p1 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [12:0] raw, input logic s1, input logic s2);
    logic [15:0] w;
    w = {raw, 3'b101};
    for (int i = 0; i < 16; i++) send_bit(w[i], s1, s2);
  endtask

  task automatic apply_stimulus(input logic [12:0] l, input logic [12:0] r);
    send_word(l, 1'b1, 1'b0);
    send_word(r, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk); rd_ack_man = 1'b1;
    @(negedge clk); rd_ack_man = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check_output({tag, " left_raw"}, 32'(left_raw), 0);
    check_output({tag, " right_raw"}, 32'(right_raw), 0);
    check_output({tag, " left"}, 32'(left), 0);
    check_output({tag, " right"}, 32'(right), 0);
    check_output({tag, " valid"}, 32'(sample_valid), 0);
    check_output({tag, " ready"}, 32'(sample_ready), 0);
    check_output({tag, " overrun"}, 32'(overrun_cnt), 0);
    check_output({tag, " p1_lost"}, 32'(p1_lost), 0);
  endtask

  initial begin
    vecs[0] = '{13'h1FFF, 13'h1C00, 16'h7FC0, 16'h8000};
    vecs[1] = '{13'h0600, 13'h0E01, 16'h0000, 16'h0004};
    vecs[2] = '{13'h03FF, 13'h09FF, 16'h0000, 16'hFFFE};
    vecs[3] = '{13'h1000, 13'h16AA, 16'hF000, 16'h0AA0};
    vecs[4] = '{13'h1955, 13'h07FF, 16'hEAA0, 16'h01FF};

    rst_n = 1'b0; ym_p1 = 1'b0; ym_so = 1'b0; ym_sh1 = 1'b0; ym_sh2 = 1'b0;
    enable = 1'b1; rd_ack_man = 1'b0; ack_on_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      base = valid_cnt;
      apply_stimulus(vecs[i].l_raw, vecs[i].r_raw);
      check_output($sformatf("vec%0d left_raw", i), 32'(left_raw), 32'(vecs[i].l_raw));
      check_output($sformatf("vec%0d right_raw", i), 32'(right_raw), 32'(vecs[i].r_raw));
      check_output($sformatf("vec%0d left", i), 32'(left), 32'(vecs[i].l_lin));
      check_output($sformatf("vec%0d right", i), 32'(right), 32'(vecs[i].r_lin));
      check_output($sformatf("vec%0d pulses", i), 32'(valid_cnt - base), 1);
      check_output($sformatf("vec%0d ready", i), 32'(sample_ready), 1);
      pulse_ack();
      check_output($sformatf("vec%0d ready after ack", i), 32'(sample_ready), 0);
    end
    check_output("overrun after acked pairs", 32'(overrun_cnt), 0);

    // Three unread pairs, then a pair acked in the same cycle it arrives.
    base = valid_cnt;
    for (int i = 1; i < 4; i++) apply_stimulus(vecs[i].l_raw, vecs[i].r_raw);
    check_output("overrun count", 32'(overrun_cnt), 2);
    check_output("overrun pulses", 32'(valid_cnt - base), 3);
    check_output("overrun left holds third", 32'(left), 32'(vecs[3].l_lin));
    check_output("overrun right holds third", 32'(right), 32'(vecs[3].r_lin));
    ack_on_valid = 1'b1;
    apply_stimulus(vecs[4].l_raw, vecs[4].r_raw);
    ack_on_valid = 1'b0;
    check_output("coincident ack ready", 32'(sample_ready), 1);
    check_output("coincident ack overrun", 32'(overrun_cnt), 2);
    check_output("coincident ack left", 32'(left), 32'(vecs[4].l_lin));
    pulse_ack();
    check_output("ready cleared", 32'(sample_ready), 0);

    // P1 stopped: watchdog saturates after 255 clk without a rising edge.
    send_bit(1'b0, 1'b0, 1'b0);
    check_output("p1_lost while running", 32'(p1_lost), 0);
    repeat (240) @(negedge clk);
    check_output("p1_lost before timeout", 32'(p1_lost), 0);
    repeat (60) @(negedge clk);
    check_output("p1_lost after timeout", 32'(p1_lost), 1);
    send_bit(1'b0, 1'b0, 1'b0);
    check_output("p1_lost after restart", 32'(p1_lost), 0);

    // Reset in the middle of a left word; the partial word must vanish.
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("midword reset");
    rst_n = 1'b1;
    base = valid_cnt;
    apply_stimulus(vecs[0].l_raw, vecs[0].r_raw);
    check_output("post reset left", 32'(left), 32'(vecs[0].l_lin));
    check_output("post reset right", 32'(right), 32'(vecs[0].r_lin));
    check_output("post reset pulses", 32'(valid_cnt - base), 1);
    pulse_ack();

    // Disable partway through a frame: nothing may be latched or announced.
    base = valid_cnt;
    send_word(13'h0123, 1'b1, 1'b0);
    enable = 1'b0;
    send_word(13'h0456, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_output("disabled pulses", 32'(valid_cnt - base), 0);
    check_output("disabled left_raw holds", 32'(left_raw), 32'(vecs[0].l_raw));
    check_output("disabled right_raw holds", 32'(right_raw), 32'(vecs[0].r_raw));
    enable = 1'b1;
    base = valid_cnt;
    apply_stimulus(vecs[4].l_raw, vecs[4].r_raw);
    check_output("reenable left", 32'(left), 32'(vecs[4].l_lin));
    check_output("reenable right", 32'(right), 32'(vecs[4].r_lin));
    check_output("reenable pulses", 32'(valid_cnt - base), 1);
    check_output("reenable ready", 32'(sample_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ym_dac_capture.md
Name: ym_dac_capture

Overview:
- Captures the YM2151 serial DAC stream (ym_so framed by ym_sh1/ym_sh2, clocked by ym_p1) in the FPGA clock domain.
- Deserialises each channel into its 13-bit floating-point word and converts it to 16-bit signed linear.
- Presents left/right pairs to the system bus with a ready/ack handshake, overrun counting and P1-loss detection.
- Sits between the YM2151 DAC pins and system_bus; its outputs are directly comparable with jt51_left/jt51_right.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on ym_p1, ym_so, ym_sh1, ym_sh2 (minimum 2).
- TIMEOUT_W, 8: width of the P1 watchdog counter; timeout is 2^TIMEOUT_W-1 clk cycles.

Ports:
- clk  in  1  system clock (16.67 MHz)
- rst_n  in  1  asynchronous active-low reset
- ym_p1  in  1  YM2151 DAC bit clock (async)
- ym_so  in  1  YM2151 serial data (async)
- ym_sh1  in  1  left-channel sample/hold strobe (async)
- ym_sh2  in  1  right-channel sample/hold strobe (async)
- enable  in  1  capture enable
- rd_ack  in  1  one-cycle pulse: bus has read the current pair
- left_raw  out  13  last left word {exp[2:0], mant[9:0]}
- right_raw  out  13  last right word {exp[2:0], mant[9:0]}
- left  out  16  left, signed linear
- right  out  16  right, signed linear
- sample_valid  out  1  one-cycle pulse when a new pair is complete
- sample_ready  out  1  unread pair available
- overrun_cnt  out  8  saturating count of pairs lost
- p1_lost  out  1  no P1 rising edge within the timeout

Behaviour:
- Reset: every output and internal register is 0; the watchdog counter is 0.
- Sync: each async input passes through SYNC_STAGES flops. A P1 rising edge (p1_rise) is detected from the last two synchronised P1 samples. Everything below advances only on p1_rise.
- Shift register: on p1_rise with enable=1, sreg[15:0] <= {so_s, sreg[15:1]}. Data arrives LSB first. In a complete word, bits [2:0] are don't-care, [12:3] are the mantissa and [15:13] the exponent.
- Strobe edges: sh1 and sh2 are sampled at each p1_rise. A falling edge is a sample of 1 followed by 0 at the next p1_rise.
  - On that edge, sreg[15:3] (the value before the current shift) is latched into left_raw (sh1) or right_raw (sh2).
  - left/right are updated on the same clk from the conversion below.
- Pairing:
  - A left word sets an internal left_got flag.
  - A right word with left_got=1 completes a pair: sample_valid=1 on the following clk (latency 1 clk after latch), and left_got is cleared.
  - A right word without left_got updates right_raw/right but produces no pulse.
  - Two lefts in a row: the second overwrites the first.
- Conversion (combinational, sub-module):
  - e = raw[12:10], m = raw[9:0].
  - e=0 gives 0.
  - Otherwise, sign-extend the 10-bit signed value {~m[9], m[8:0]} to 16 bits, then arithmetic shift left by (e-1). Maximum shift is 6, so no overflow.
- Handshake:
  - sample_valid sets sample_ready; rd_ack clears it.
  - If sample_valid and rd_ack occur in the same cycle, sample_ready stays 1.
  - rd_ack while sample_ready=0 is ignored.
- Overrun: sample_valid while sample_ready=1 and rd_ack=0 increments overrun_cnt, saturating at 255. The new data overwrites the unread pair. overrun_cnt clears only on reset.
- Watchdog:
  - The counter increments every clk, resets to 0 on p1_rise, and saturates at all-ones.
  - p1_lost=1 while saturated; it clears on the clk after the next p1_rise.
  - The watchdog runs regardless of enable.
- enable=0:
  - sreg and left_got are held at 0; no latching and no sample_valid.
  - Data outputs and sample_ready hold their values; rd_ack is still honoured.
  - Re-enable starts capture cleanly at the next full frame.
- Reset mid-frame: everything returns to 0, and the partial word is discarded.

Decomposition:
- Shared package ym_dac_pkg holds:
  - field positions MANT_LSB=3, MANT_W=10, EXP_LSB=13, EXP_W=3, RAW_W=13, LIN_W=16;
  - the zero-exponent constant.
- One sub-module, ym_dac_exp2lin: combinational conversion raw[12:0] -> lin[15:0]. It is instantiated twice.

Test Plan:
- Left raw {e=7, m=0x3FF}, then right raw {e=7, m=0x000}, sent LSB first with sh1 then sh2 falling -> left=0x7FC0, right=0x8000, one sample_valid pulse, sample_ready=1.
- Raw {e=1, m=0x200} -> lin 0x0000; raw {e=3, m=0x201} -> 0x0004; raw {e=0, m=0x3FF} -> 0x0000.
- Three complete pairs with no rd_ack -> overrun_cnt=2, outputs hold the third pair; rd_ack on the same cycle as the next sample_valid -> sample_ready stays 1, overrun_cnt unchanged.
- Stop ym_p1 for 300 clk with TIMEOUT_W=8 -> p1_lost=1 from cycle 255; restart P1 -> p1_lost=0 after the first p1_rise.
- Assert rst_n low mid-word, then release and send a full frame -> all outputs read 0 during reset; the first full pair after release decodes correctly.
- enable=0 during a frame -> no sample_valid; enable=1 -> the next full pair is captured correctly.
